level_2_predictor: RTL and testbench

- Two-level (GHR-correlated) branch predictor for a 5-bit-PC toy core.
- Each valid cycle, the block is presented with a branch PC and its resolved effective address.
- It predicts taken/not-taken from a pattern history table (PHT) of 2-bit saturating counters, indexed by low PC bits concatenated with a global history register (GHR).
- It then resolves the actual outcome and trains the counter and the GHR.

---
 rtl/level_2_predictor.sv | 100 ++++++++++
 tb/tb_level_2_predictor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/level_2_predictor.sv
// Two-level GHR-correlated branch predictor: PHT of 2-bit counters indexed by {PC low bits, GHR}.
// Optional statistics counters are enabled with `define LEVEL2_PRED_STATS_EN.
module level_2_predictor #(
   parameter int PC_W       = 5,
   parameter int GHR_W      = 2,
   parameter int PC_IDX_W   = 3,
   parameter int INSTR_STEP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [PC_W-1:0]   PC,
   input  logic [PC_W-1:0]   effective_address,
   output logic              prediction,
   output logic              actual_taken,
   output logic              mispredict,
   output logic [GHR_W-1:0]  ghr
`ifdef LEVEL2_PRED_STATS_EN
   ,
   output logic [15:0]       branch_count,
   output logic [15:0]       mispredict_count
`endif
);

   localparam int IDX_W = PC_IDX_W + GHR_W;
   localparam int DEPTH = 1 << IDX_W;

   logic [1:0]       r_pht [DEPTH];
   logic [GHR_W-1:0] r_ghr;
   logic             r_prediction;
   logic             r_actual_taken;
   logic             r_mispredict;

   logic [PC_W-1:0]  w_fall_through;
   logic             w_taken;
   logic [IDX_W-1:0] w_idx;
   logic [1:0]       w_ctr;
   logic [1:0]       w_ctr_next;
   logic             w_pred;

   // The fall-through add wraps at PC_W bits, so a branch at the top of memory falls through to 0.
   assign w_fall_through = PC + PC_W'(INSTR_STEP);
   assign w_taken        = (effective_address != w_fall_through);
   assign w_idx          = {PC[PC_IDX_W-1:0], r_ghr};
   assign w_ctr          = r_pht[w_idx];
   assign w_pred         = w_ctr[1];

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_ctr_next = w_ctr;
      if (w_taken && (w_ctr != 2'b11))
         w_ctr_next = w_ctr + 2'b01;
      else if (!w_taken && (w_ctr != 2'b00))
         w_ctr_next = w_ctr - 2'b01;
   end

   // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the PHT is reset explicitly because predictions depend on the weakly-NT start state.
         for (int i = 0; i < DEPTH; i++)
            r_pht[i] <= 2'b01;
         r_ghr          <= '0;
         r_prediction   <= 1'b0;
         r_actual_taken <= 1'b0;
         r_mispredict   <= 1'b0;
      end else if (valid) begin
         r_pht[w_idx]   <= w_ctr_next;
         r_ghr          <= {r_ghr[GHR_W-2:0], w_taken};
         r_prediction   <= w_pred;
         r_actual_taken <= w_taken;
         r_mispredict   <= w_pred ^ w_taken;
      end
   end

   assign prediction   = r_prediction;
   assign actual_taken = r_actual_taken;
   assign mispredict   = r_mispredict;
   assign ghr          = r_ghr;

`ifdef LEVEL2_PRED_STATS_EN
   logic [15:0] r_branch_count;
   logic [15:0] r_mispredict_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else if (valid) begin
         r_branch_count <= r_branch_count + 16'd1;
         if (w_pred ^ w_taken)
            r_mispredict_count <= r_mispredict_count + 16'd1;
      end
   end

   assign branch_count     = r_branch_count;
   assign mispredict_count = r_mispredict_count;
`endif

endmodule

// File: tb/tb_level_2_predictor.sv
// Scoreboard bench for level_2_predictor: directed branches push hand-computed results,
// a monitor pops and compares one cycle after each driven cycle.
module tb_level_2_predictor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [4:0] pc = '0;
   logic [4:0] ea = '0;
   logic       prediction;
   logic       actual_taken;
   logic       mispredict;
   logic [1:0] ghr;
`ifdef LEVEL2_PRED_STATS_EN
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;
`endif

   always #5 clk = ~clk;

   level_2_predictor dut (
      .clk               (clk),
      .rst               (rst),
      .valid             (valid),
      .PC                (pc),
      .effective_address (ea),
      .prediction        (prediction),
      .actual_taken      (actual_taken),
      .mispredict        (mispredict),
      .ghr               (ghr)
`ifdef LEVEL2_PRED_STATS_EN
      ,
      .branch_count      (branch_count),
      .mispredict_count  (mispredict_count)
`endif
   );

   typedef struct {
      int         id;
      logic       p;
      logic       t;
      logic       m;
      logic [1:0] g;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_push = 0;

   task automatic push(input logic p, input logic t, input logic m, input logic [1:0] g);
      exp_t e;
      e.id = n_push;
      e.p  = p;
      e.t  = t;
      e.m  = m;
      e.g  = g;
      q.push_back(e);
      n_push++;
   endtask

   task automatic br(input logic [4:0] a, input logic [4:0] e,
                     input logic p, input logic t, input logic m, input logic [1:0] g);
      @(negedge clk);
      rst   = 1'b0;
      valid = 1'b1;
      pc    = a;
      ea    = e;
      push(p, t, m, g);
   endtask

   task automatic idle(input logic p, input logic t, input logic m, input logic [1:0] g);
      @(negedge clk);
      rst   = 1'b0;
      valid = 1'b0;
      pc    = 'x;
      ea    = 'x;
      push(p, t, m, g);
   endtask

   task automatic do_reset(input logic v);
      @(negedge clk);
      rst   = 1'b1;
      valid = v;
      pc    = 5'b01100;
      ea    = 5'b01001;
      push(1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() > 0; i++)
         @(negedge clk);
      if (q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_timeout: %0d results still pending, required 0", q.size());
         q.delete();
      end
   endtask

   // Monitor: one result per driven cycle, sampled just after the capturing edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (q.size() > 0) begin
            #1;
            e = q.pop_front();
            n_vec++;
            if ({prediction, actual_taken, mispredict, ghr} !== {e.p, e.t, e.m, e.g}) begin
               n_bad++;
               $display("FAIL vec%0d: got pred=%b taken=%b misp=%b ghr=%b, expected pred=%b taken=%b misp=%b ghr=%b",
                        e.id, prediction, actual_taken, mispredict, ghr, e.p, e.t, e.m, e.g);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [4:0] PC_LOOP = 5'b01100;
   localparam logic [4:0] EA_T    = 5'b01001;
   localparam logic [4:0] EA_NT   = 5'b10000;

   initial begin
      do_reset(1'b0);

      // Pass 1 from reset: T,NT,T,T,NT with all counters weakly NT.
      br(PC_LOOP, EA_T,  1'b0, 1'b1, 1'b1, 2'b01);
      br(PC_LOOP, EA_NT, 1'b0, 1'b0, 1'b0, 2'b10);
      br(PC_LOOP, EA_T,  1'b0, 1'b1, 1'b1, 2'b01);
      br(PC_LOOP, EA_T,  1'b0, 1'b1, 1'b1, 2'b11);
      br(PC_LOOP, EA_NT, 1'b0, 1'b0, 1'b0, 2'b10);
      // Passes 2-4: trained, only the 4th branch mispredicts.
      for (int pass = 0; pass < 3; pass++) begin
         br(PC_LOOP, EA_T,  1'b1, 1'b1, 1'b0, 2'b01);
         br(PC_LOOP, EA_NT, 1'b0, 1'b0, 1'b0, 2'b10);
         br(PC_LOOP, EA_T,  1'b1, 1'b1, 1'b0, 2'b01);
         br(PC_LOOP, EA_T,  1'b0, 1'b1, 1'b1, 2'b11);
         br(PC_LOOP, EA_NT, 1'b0, 1'b0, 1'b0, 2'b10);
      end

`ifdef LEVEL2_PRED_STATS_EN
      drain();
      n_vec++;
      if (branch_count !== 16'd20 || mispredict_count !== 16'd6) begin
         n_bad++;
         $display("FAIL stats: got branches=%0d mispredicts=%0d, expected 20 and 6",
                  branch_count, mispredict_count);
      end
`endif

      // Saturation at PC=0: two warmup takens bring ghr to 11, then six takens at ghr=11.
      br(5'b00000, 5'b01000, 1'b0, 1'b1, 1'b1, 2'b01);
      br(5'b00000, 5'b01000, 1'b0, 1'b1, 1'b1, 2'b11);
      br(5'b00000, 5'b01000, 1'b0, 1'b1, 1'b1, 2'b11);
      for (int i = 0; i < 5; i++)
         br(5'b00000, 5'b01000, 1'b1, 1'b1, 1'b0, 2'b11);
      br(5'b00000, 5'b00100, 1'b1, 1'b0, 1'b1, 2'b10);
      // Refill ghr=11 via PC=5, then probe the counter: 10 still predicts T, then 01 predicts NT.
      br(5'b00101, 5'b00000, 1'b0, 1'b1, 1'b1, 2'b01);
      br(5'b00101, 5'b00000, 1'b0, 1'b1, 1'b1, 2'b11);
      br(5'b00000, 5'b00100, 1'b1, 1'b0, 1'b1, 2'b10);
      br(5'b00101, 5'b00000, 1'b1, 1'b1, 1'b0, 2'b01);
      br(5'b00101, 5'b00000, 1'b1, 1'b1, 1'b0, 2'b11);
      br(5'b00000, 5'b00100, 1'b0, 1'b0, 1'b0, 2'b10);

      // Fall-through wrap at PC=28.
      br(5'b11100, 5'b00000, 1'b1, 1'b0, 1'b1, 2'b00);
      br(5'b11100, 5'b00001, 1'b1, 1'b1, 1'b0, 2'b01);

      // Idle with undriven inputs: everything holds.
      for (int i = 0; i < 3; i++)
         idle(1'b1, 1'b1, 1'b0, 2'b01);
      br(5'b00101, 5'b00000, 1'b1, 1'b1, 1'b0, 2'b11);

      // Reset wins over a concurrent valid; the strongly-T entry at idx 10000 is back to weakly NT.
      do_reset(1'b1);
      br(PC_LOOP, EA_T, 1'b0, 1'b1, 1'b1, 2'b01);

      @(negedge clk);
      valid = 1'b0;
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
